// File: rtl/xalu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : xalu_pkg
//  Description : Shared constants and types for the nibble-serial ALU
//                sequencer: slice width, function codes and FSM states.
//                The FIX state exists only when XALU_SEQ_EAC_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package xalu_pkg;

  // Width of the combinational ALU slice
  localparam int XALU_NIB_W = 4;

  // Function codes understood by the slice
  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_AND   = 3'd1;
  localparam logic [2:0] ALU_OR    = 3'd2;
  localparam logic [2:0] ALU_XOR   = 3'd3;
  localparam logic [2:0] ALU_PASSA = 3'd4;
  localparam logic [2:0] ALU_PASSB = 3'd5;
  localparam logic [2:0] ALU_SHR   = 3'd6;
  localparam logic [2:0] ALU_SHL   = 3'd7;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
`ifdef XALU_SEQ_EAC_EN
    ,
    ST_FIX  = 2'd3
`endif
  } xalu_state_t;

endpackage : xalu_pkg
`default_nettype wire

// File: rtl/xalu_nibble_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : xalu_nibble_seq_if
//  Description : Request / result handshake bundle of the nibble-serial ALU
//                sequencer. master = requester/consumer, slave = sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface xalu_nibble_seq_if
  import xalu_pkg::*;
#(
  parameter int NIBBLES = 4
) ();

  localparam int c_W = XALU_NIB_W * NIBBLES;

  // Request side
  logic           start_valid;
  logic           start_ready;
  logic [2:0]     op;
  logic           com;
  logic           cin;
  logic [c_W-1:0] a_word;
  logic [c_W-1:0] b_word;

  // Result side
  logic           res_valid;
  logic           res_ready;
  logic [c_W-1:0] res_word;
  logic           res_carry;
  logic           res_zero;
  logic           res_neg_zero;
  logic           res_equ;

  modport master (
    output start_valid, op, com, cin, a_word, b_word, res_ready,
    input  start_ready, res_valid, res_word, res_carry, res_zero,
           res_neg_zero, res_equ
  );

  modport slave (
    input  start_valid, op, com, cin, a_word, b_word, res_ready,
    output start_ready, res_valid, res_word, res_carry, res_zero,
           res_neg_zero, res_equ
  );

endinterface : xalu_nibble_seq_if
`default_nettype wire

// File: rtl/xalu_nib_lane.sv
`default_nettype none
// ============================================================================
//  Module      : xalu_nib_lane
//  Description : Combinational nibble steering. Selects one nibble of the A
//                and B operand words and inserts a result nibble into the
//                result word. msb_first reverses the index (shift-right runs
//                from the most significant nibble down).
//  Revision    : 1.0 - initial release
// ============================================================================
module xalu_nib_lane
  import xalu_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic [XALU_NIB_W*NIBBLES-1:0] a_word,
  input  logic [XALU_NIB_W*NIBBLES-1:0] b_word,
  input  logic [$clog2(NIBBLES)-1:0]    sel_idx,
  input  logic                          msb_first,
  output logic [XALU_NIB_W-1:0]         a_nib,
  output logic [XALU_NIB_W-1:0]         b_nib,
  input  logic [XALU_NIB_W*NIBBLES-1:0] res_word,
  input  logic [$clog2(NIBBLES)-1:0]    ins_idx,
  input  logic [XALU_NIB_W-1:0]         ins_nib,
  output logic [XALU_NIB_W*NIBBLES-1:0] res_ins
);

  localparam int                   c_IDX_W    = $clog2(NIBBLES);
  localparam logic [c_IDX_W-1:0]   c_LAST_IDX = c_IDX_W'(NIBBLES - 1);

  logic [c_IDX_W-1:0] w_sel_pos;
  logic [c_IDX_W-1:0] w_ins_pos;

  // Map beat index to physical nibble position
  always_comb begin
    w_sel_pos = msb_first ? (c_LAST_IDX - sel_idx) : sel_idx;
    w_ins_pos = msb_first ? (c_LAST_IDX - ins_idx) : ins_idx;
  end

  // Operand nibble select
  always_comb begin
    a_nib = a_word[w_sel_pos*XALU_NIB_W +: XALU_NIB_W];
    b_nib = b_word[w_sel_pos*XALU_NIB_W +: XALU_NIB_W];
  end

  // Result nibble insert
  always_comb begin
    res_ins = res_word;
    res_ins[w_ins_pos*XALU_NIB_W +: XALU_NIB_W] = ins_nib;
  end

endmodule : xalu_nib_lane
`default_nettype wire

// File: rtl/xalu_nibble_seq.sv
`default_nettype none
// ============================================================================
//  Module      : xalu_nibble_seq
//  Description : Word-serial sequencer around a combinational 4-bit ALU
//                slice. Runs one nibble per clock, chains carries between
//                beats and returns the assembled word plus flags through a
//                valid/ready handshake.
//                Optional: XALU_SEQ_EAC_EN adds an end-around-carry FIX pass
//                for ones'-complement ADD.
//  Revision    : 1.0 - initial release
// ============================================================================
module xalu_nibble_seq
  import xalu_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  xalu_nibble_seq_if.slave      bus,
  output logic [XALU_NIB_W-1:0] alu_a,
  output logic [XALU_NIB_W-1:0] alu_b,
  output logic [2:0]            alu_f,
  output logic                  alu_ci_right,
  output logic                  alu_ci_left,
  output logic                  alu_com,
  input  logic [XALU_NIB_W-1:0] alu_d,
  input  logic                  alu_co_left,
  input  logic                  alu_co_right,
  input  logic                  alu_zero,
  input  logic                  alu_neg_zero,
  input  logic                  alu_equ
);

  localparam int                 c_W        = XALU_NIB_W * NIBBLES;
  localparam int                 c_IDX_W    = $clog2(NIBBLES);
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NIBBLES - 1);

  xalu_state_t          r_state;
  logic [c_IDX_W-1:0]   r_idx;
  logic [2:0]           r_op;
  logic                 r_com;
  logic [c_W-1:0]       r_a;
  logic [c_W-1:0]       r_b;
  logic [c_W-1:0]       r_res_word;
  logic                 r_res_valid;
  logic                 r_res_carry;
  logic                 r_zero;
  logic                 r_neg_zero;
  logic                 r_equ;

  logic                 w_idle;
  logic                 w_last;
  logic                 w_shr_sel;
  logic [c_IDX_W-1:0]   w_sel_idx;
  logic [c_W-1:0]       w_a_src;
  logic [c_W-1:0]       w_b_src;
  logic [XALU_NIB_W-1:0] w_a_nib;
  logic [XALU_NIB_W-1:0] w_b_nib;
  logic [c_W-1:0]       w_res_ins;
  logic                 w_carry_out;

  // In IDLE the lane looks at the incoming request so the first beat's
  // nibble is registered on the accept edge; afterwards it looks one beat
  // ahead into the latched operands.
  assign w_idle    = (r_state == ST_IDLE);
  assign w_last    = (r_idx == c_LAST_IDX);
  assign w_shr_sel = w_idle ? (bus.op == ALU_SHR) : (r_op == ALU_SHR);
  assign w_sel_idx = w_idle ? '0 : (r_idx + 1'b1);
  assign w_a_src   = w_idle ? bus.a_word : r_a;
  assign w_b_src   = w_idle ? bus.b_word : r_b;

  // Word carry taken from the final beat of the first pass
  assign w_carry_out = ((r_op == ALU_ADD) || (r_op == ALU_SHL)) ? alu_co_left  :
                       (r_op == ALU_SHR)                        ? alu_co_right : 1'b0;

`ifdef XALU_SEQ_EAC_EN
  logic w_need_fix;
  assign w_need_fix = (r_state == ST_RUN) && (r_op == ALU_ADD) && !r_com && alu_co_left;
`endif

  xalu_nib_lane #(
    .NIBBLES (NIBBLES)
  ) u_lane (
    .a_word    (w_a_src),
    .b_word    (w_b_src),
    .sel_idx   (w_sel_idx),
    .msb_first (w_shr_sel),
    .a_nib     (w_a_nib),
    .b_nib     (w_b_nib),
    .res_word  (r_res_word),
    .ins_idx   (r_idx),
    .ins_nib   (alu_d),
    .res_ins   (w_res_ins)
  );

  assign bus.start_ready  = w_idle;
  assign bus.res_valid    = r_res_valid;
  assign bus.res_word     = r_res_word;
  assign bus.res_carry    = r_res_carry;
  assign bus.res_zero     = r_zero;
  assign bus.res_neg_zero = r_neg_zero;
  assign bus.res_equ      = r_equ;

  // Sequencer FSM: accept, nibble beats, optional FIX pass, result hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_op         <= '0;
      r_com        <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_res_word   <= '0;
      r_res_valid  <= 1'b0;
      r_res_carry  <= 1'b0;
      r_zero       <= 1'b0;
      r_neg_zero   <= 1'b0;
      r_equ        <= 1'b0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_f        <= '0;
      alu_ci_right <= 1'b0;
      alu_ci_left  <= 1'b0;
      alu_com      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start_valid) begin
            r_state      <= ST_RUN;
            r_idx        <= '0;
            r_op         <= bus.op;
            r_com        <= bus.com;
            r_a          <= bus.a_word;
            r_b          <= bus.b_word;
            r_res_word   <= '0;
            r_res_carry  <= 1'b0;
            r_zero       <= 1'b1;
            r_neg_zero   <= 1'b1;
            r_equ        <= 1'b1;
            alu_a        <= w_a_nib;
            alu_b        <= w_b_nib;
            alu_f        <= bus.op;
            alu_com      <= bus.com;
            alu_ci_right <= (bus.op == ALU_SHR) ? 1'b0 : bus.cin;
            alu_ci_left  <= (bus.op == ALU_SHR) ? bus.cin : 1'b0;
          end
        end

        ST_RUN
`ifdef XALU_SEQ_EAC_EN
        , ST_FIX
`endif
        : begin
          r_res_word <= w_res_ins;
          r_zero     <= r_zero & alu_zero;
          r_neg_zero <= r_neg_zero & alu_neg_zero;
          if (r_state == ST_RUN) begin
            r_equ <= r_equ & alu_equ;
          end
          if (!w_last) begin
            r_idx        <= r_idx + 1'b1;
            alu_a        <= w_a_nib;
            alu_b        <= w_b_nib;
            alu_f        <= r_op;
            alu_com      <= r_com;
            alu_ci_right <= (r_op == ALU_SHR) ? 1'b0 : alu_co_left;
            alu_ci_left  <= (r_op == ALU_SHR) ? alu_co_right : 1'b0;
          end else begin
            if (r_state == ST_RUN) begin
              r_res_carry <= w_carry_out;
            end
            r_state      <= ST_DONE;
            r_res_valid  <= 1'b1;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_f        <= '0;
            alu_ci_right <= 1'b0;
            alu_ci_left  <= 1'b0;
            alu_com      <= 1'b0;
`ifdef XALU_SEQ_EAC_EN
            // Second pass adds the carry back in: A = first-pass word, B = 0
            if (w_need_fix) begin
              r_state      <= ST_FIX;
              r_res_valid  <= 1'b0;
              r_idx        <= '0;
              r_a          <= w_res_ins;
              r_b          <= '0;
              r_zero       <= 1'b1;
              r_neg_zero   <= 1'b1;
              alu_a        <= w_res_ins[XALU_NIB_W-1:0];
              alu_b        <= '0;
              alu_f        <= ALU_ADD;
              alu_com      <= 1'b0;
              alu_ci_right <= 1'b1;
              alu_ci_left  <= 1'b0;
            end
`endif
          end
        end

        ST_DONE: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : xalu_nibble_seq
`default_nettype wire

// File: tb/tb_xalu_nibble_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xalu_nibble_seq
//  Description : Self-checking bench for xalu_nibble_seq. Models the 4-bit
//                slice behaviourally and predicts word results with plain
//                full-width arithmetic. Honours XALU_SEQ_EAC_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_xalu_nibble_seq;
  import xalu_pkg::*;

  localparam int N = 4;
  localparam int W = XALU_NIB_W * N;
`ifdef XALU_SEQ_EAC_EN
  localparam bit EAC_ON = 1'b1;
`else
  localparam bit EAC_ON = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] alu_a, alu_b, alu_d;
  logic [2:0] alu_f;
  logic       alu_ci_right, alu_ci_left, alu_com;
  logic       alu_co_left, alu_co_right, alu_zero, alu_neg_zero, alu_equ;

  int n_checks = 0;
  int n_fail   = 0;

  xalu_nibble_seq_if #(.NIBBLES(N)) bus ();

  xalu_nibble_seq #(.NIBBLES(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_f        (alu_f),
    .alu_ci_right (alu_ci_right),
    .alu_ci_left  (alu_ci_left),
    .alu_com      (alu_com),
    .alu_d        (alu_d),
    .alu_co_left  (alu_co_left),
    .alu_co_right (alu_co_right),
    .alu_zero     (alu_zero),
    .alu_neg_zero (alu_neg_zero),
    .alu_equ      (alu_equ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 4-bit slice
  always_comb begin
    logic [4:0] sum;
    logic [3:0] raw;
    sum          = '0;
    raw          = '0;
    alu_co_left  = 1'b0;
    alu_co_right = 1'b0;
    case (alu_f)
      ALU_ADD: begin
        sum         = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_ci_right};
        raw         = sum[3:0];
        alu_co_left = sum[4];
      end
      ALU_AND:   raw = alu_a & alu_b;
      ALU_OR:    raw = alu_a | alu_b;
      ALU_XOR:   raw = alu_a ^ alu_b;
      ALU_PASSA: raw = alu_a;
      ALU_PASSB: raw = alu_b;
      ALU_SHR: begin
        raw          = {alu_ci_left, alu_a[3:1]};
        alu_co_right = alu_a[0];
      end
      default: begin
        raw         = {alu_a[2:0], alu_ci_right};
        alu_co_left = alu_a[3];
      end
    endcase
    alu_d        = alu_com ? ~raw : raw;
    alu_zero     = (alu_d == 4'h0);
    alu_neg_zero = (alu_d == 4'hF);
    alu_equ      = (alu_a == alu_b);
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] alu_outs();
    return 64'({alu_a, alu_b, alu_f, alu_ci_right, alu_ci_left, alu_com});
  endfunction

  // One full operation: predict, issue, watch beats, check result, hold, release
  task automatic do_op(input logic [2:0] op, input logic cm, input logic ci,
                       input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    logic [W:0]   s;
    logic [W-1:0] r, rc;
    logic         ec, eq;
    int           elat, lat, pos;
    s  = '0;
    r  = '0;
    ec = 1'b0;
    case (op)
      ALU_ADD: begin
        s  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        r  = s[W-1:0];
        ec = s[W];
      end
      ALU_AND:   r = a & b;
      ALU_OR:    r = a | b;
      ALU_XOR:   r = a ^ b;
      ALU_PASSA: r = a;
      ALU_PASSB: r = b;
      ALU_SHR: begin
        r  = {ci, a[W-1:1]};
        ec = a[0];
      end
      default: begin
        r  = {a[W-2:0], ci};
        ec = a[W-1];
      end
    endcase
    eq   = (a == b);
    rc   = cm ? ~r : r;
    elat = N;
    if (EAC_ON && op == ALU_ADD && !cm && ec) begin
      rc   = r + 1'b1;
      elat = 2 * N;
    end

    check_val("start_ready_idle", 64'(bus.start_ready), 64'(1));
    bus.op          = op;
    bus.com         = cm;
    bus.cin         = ci;
    bus.a_word      = a;
    bus.b_word      = b;
    bus.res_ready   = (hold == 0);
    bus.start_valid = 1'b1;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    bus.a_word      = W'($urandom());
    bus.b_word      = W'($urandom());
    bus.op          = 3'($urandom_range(0, 7));
    bus.com         = 1'($urandom_range(0, 1));
    bus.cin         = 1'($urandom_range(0, 1));

    lat = 0;
    while (bus.res_valid !== 1'b1 && lat < 4 * N + 8) begin
      if (lat < N) begin
        pos = (op == ALU_SHR) ? (N - 1 - lat) : lat;
        check_val("beat_alu_a", 64'(alu_a), 64'(a[pos*4 +: 4]));
        check_val("beat_alu_f", 64'(alu_f), 64'(op));
      end
      @(posedge clk); #1;
      lat++;
    end
    check_val("latency",      64'(lat),              64'(elat));
    check_val("res_word",     64'(bus.res_word),     64'(rc));
    check_val("res_carry",    64'(bus.res_carry),    64'(ec));
    check_val("res_zero",     64'(bus.res_zero),     64'(rc == '0));
    check_val("res_neg_zero", 64'(bus.res_neg_zero), 64'(rc == '1));
    check_val("res_equ",      64'(bus.res_equ),      64'(eq));
    check_val("alu_idle_done", alu_outs(), 64'(0));

    for (int i = 0; i < hold; i++) begin
      bus.start_valid = 1'b1;
      bus.a_word      = W'($urandom());
      @(posedge clk); #1;
      check_val("hold_valid",       64'(bus.res_valid),   64'(1));
      check_val("hold_word",        64'(bus.res_word),    64'(rc));
      check_val("hold_start_ready", 64'(bus.start_ready), 64'(0));
    end
    bus.start_valid = 1'b0;
    bus.res_ready   = 1'b1;
    @(posedge clk); #1;
    check_val("release_valid",       64'(bus.res_valid),   64'(0));
    check_val("release_start_ready", 64'(bus.start_ready), 64'(1));
    check_val("release_word",        64'(bus.res_word),    64'(rc));
  endtask

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]   rop;
    logic [W-1:0] ra, rb;
    rst             = 1'b1;
    bus.start_valid = 1'b0;
    bus.res_ready   = 1'b0;
    bus.op          = '0;
    bus.com         = 1'b0;
    bus.cin         = 1'b0;
    bus.a_word      = '0;
    bus.b_word      = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_res_valid",   64'(bus.res_valid),   64'(0));
    check_val("rst_start_ready", 64'(bus.start_ready), 64'(1));
    check_val("rst_res_word",    64'(bus.res_word),    64'(0));
    check_val("rst_flags", 64'({bus.res_carry, bus.res_zero, bus.res_neg_zero, bus.res_equ}), 64'(0));
    check_val("rst_alu_outs", alu_outs(), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed scenarios
    do_op(ALU_ADD, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 0);
    do_op(ALU_ADD, 1'b0, 1'b0, 16'h00FF, 16'h0001, 0);
    do_op(ALU_SHL, 1'b0, 1'b1, 16'h8001, 16'h0000, 0);
    do_op(ALU_SHR, 1'b0, 1'b0, 16'h8001, 16'h0000, 0);
    do_op(ALU_XOR, 1'b0, 1'b0, 16'h1234, 16'h1234, 0);
    do_op(ALU_XOR, 1'b1, 1'b0, 16'h1234, 16'h1234, 0);
    do_op(ALU_ADD, 1'b0, 1'b0, 16'hFFFE, 16'h0002, 5);

    // Reset in the middle of beat 2
    bus.op          = ALU_ADD;
    bus.a_word      = 16'h1111;
    bus.b_word      = 16'h2222;
    bus.res_ready   = 1'b1;
    bus.start_valid = 1'b1;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_val("midrst_alu_outs",    alu_outs(),            64'(0));
    check_val("midrst_res_valid",   64'(bus.res_valid),    64'(0));
    check_val("midrst_start_ready", 64'(bus.start_ready),  64'(1));
    bus.start_valid = 1'b1;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    check_val("inrst_alu_outs", alu_outs(), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N + 2; i++) begin
      @(posedge clk); #1;
      check_val("postrst_res_valid",   64'(bus.res_valid),   64'(0));
      check_val("postrst_start_ready", 64'(bus.start_ready), 64'(1));
    end

    // Randomized operations
    for (int i = 0; i < 80; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = W'($urandom());
      rb  = W'($urandom());
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ~ra;
        default: ;
      endcase
      do_op(rop, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rb,
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_xalu_nibble_seq
`default_nettype wire

// File: doc/xalu_nibble_seq.md
# xalu_nibble_seq

Word-serial sequencer that runs 4·NIBBLES-bit operations through the existing combinational 4-bit ALU slice, one nibble per clock. It sits directly around the slice. Upstream, it accepts a full-width operation. Each beat it drives the slice's A/B/function/carry/complement inputs, captures the slice's result nibble, carries and status, and chains the carry into the next beat. Downstream, it presents the assembled word and flags through a valid/ready handshake.

## Interface
- NIBBLES, default 4: number of nibble beats; word width W = 4·NIBBLES; legal values are 2 to 8.

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start_valid  in  1  operation request
- start_ready  out  1  sequencer can accept a request
- op  in  3  function code: 0 ADD, 1 AND, 2 OR, 3 XOR, 4 PASSA, 5 PASSB, 6 SHR, 7 SHL
- com  in  1  ones'-complement the output
- cin  in  1  carry-in (ADD) or shift-in bit (SHL/SHR)
- a_word, b_word  in  W  operands
- alu_a, alu_b  out  4  current nibble to the slice
- alu_f  out  3  function code to the slice
- alu_ci_right, alu_ci_left, alu_com  out  1  slice carry-in and complement inputs
- alu_d  in  4  slice result nibble
- alu_co_left, alu_co_right, alu_zero, alu_neg_zero, alu_equ  in  1  slice carry and status outputs
- res_valid  out  1  result available
- res_ready  in  1  consumer takes the result
- res_word  out  W  assembled result
- res_carry, res_zero, res_neg_zero, res_equ  out  1  word-level flags

## Operation
- States are IDLE, RUN and DONE, plus FIX when end-around carry is compiled in.
- start_ready is 1 exactly in IDLE.
- **Accept** (start_valid & start_ready): latch op, com, cin, a_word and b_word. Clear the beat index. Enter RUN.
- **RUN, beat k:** the alu_* outputs are driven from registered state.
  - Nibble order: ops 0–5 and 7 go LSB-first, so k selects nibble k. SHR goes MSB-first, so k selects nibble NIBBLES−1−k.
  - Carry chaining, ops 0–5 and 7: alu_ci_right is cin on the first beat, then the previous alu_co_left. alu_ci_left is 0.
  - Carry chaining, SHR: alu_ci_left is cin on the first beat, then the previous alu_co_right. alu_ci_right is 0.
  - On each edge: write alu_d into its nibble of res_word; AND alu_zero, alu_neg_zero and alu_equ into the running flags (which start at 1); advance k.
- **Final beat edge:** enter DONE.
  - res_carry is the last alu_co_left for ADD/SHL and the last alu_co_right for SHR; it is 0 for all other ops.
- **DONE:** res_valid is 1. Outputs hold until res_ready is sampled high, then the block returns to IDLE.
  - res_word and the flags keep their value until the next accept.
  - A new request can be accepted only once the block is back in IDLE; no overlap.
- **Outside RUN/FIX:** alu_a, alu_b, alu_f and all alu carry/complement outputs are 0.
- **Reset:**
  - State goes to IDLE.
  - res_valid, res_word, res_carry, res_zero, res_neg_zero, res_equ and every alu_* output go to 0.
  - start_ready reads 1; handshakes while rst is high are ignored.
  - Reset asserted mid-RUN or mid-DONE aborts the operation with no result delivered.

## Timing
- The slice is combinational. Its response must settle within one clk period of the registered alu_* outputs.
- Latency is measured from the accept edge to res_valid high. It is NIBBLES cycles, or 2·NIBBLES cycles when FIX runs.
- Throughput is one operation per NIBBLES+2 cycles when res_ready is held at 1: RUN beats, then one DONE cycle, then one IDLE cycle.
- res_ready high in the same cycle res_valid rises completes the handshake on that edge.

## Configuration
- **XALU_SEQ_EAC_EN defined:** end-around carry for ones'-complement ADD.
  - Condition: op=ADD, com=0 and first-pass carry = 1.
  - FIX runs NIBBLES further beats with A = the first-pass res_word, B = 0, op ADD, and the first beat's alu_ci_right = 1.
  - res_word and the zero/neg_zero flags come from the FIX pass. res_carry is the first-pass carry. res_equ is from the first pass.
- **Undefined:** the FIX state and its logic are absent; ADD ends after one pass.

## Structure
- Shared package xalu_pkg holds:
  - the op encoding constants ALU_ADD through ALU_SHL;
  - the slice width constant XALU_NIB_W = 4;
  - the FSM state typedef.
- One sub-module, xalu_nib_lane: a combinational nibble select (word, index, direction → nibble) plus a nibble-insert helper. It is used for A/B select and for result writeback.
- The ALU slice itself is not instantiated here; the top level wires it to the alu_* ports.

## Test plan
All scenarios use NIBBLES=4.
- **ADD, carry out:** 0xFFFF + 0x0001, cin=0 → res 0x0000, carry=1, zero=1. res_valid rises 4 cycles after accept.
- **ADD, internal carry:** 0x00FF + 0x0001 → 0x0100, carry=0, zero=0.
- **Shifts:**
  - SHL a=0x8001, cin=1 → 0x0003, carry=1.
  - SHR a=0x8001, cin=0 → 0x4000, carry=1; check MSB-first beat order on alu_a.
- **XOR and complement:**
  - XOR a=b=0x1234, com=0 → 0x0000, zero=1, equ=1.
  - Same with com=1 → 0xFFFF, neg_zero=1, zero=0.
- **End-around carry:** ADD 0xFFFE + 0x0002, com=0.
  - Without the macro → 0x0000, carry=1, latency 4.
  - With XALU_SEQ_EAC_EN → 0x0001, carry=1, latency 8.
- **Backpressure and reset:**
  - Hold res_ready=0 for 5 cycles: the result holds, start_ready=0, and a new start_valid is not accepted.
  - Assert rst at beat 2: res_valid stays 0 and all alu_* outputs go to 0.
